// File: rtl/rpsc_pkg.sv
// Shared types and width helpers for the RPSC interlock sequencer.
package rpsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRIP = 2'd2,
        COOL = 2'd3
    } seq_state_t;

    // Bits needed to hold a counter that reaches n (inclusive).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rpsc_interlock_seq_if.sv
// Operator / fault / lamp bundle of the RPSC interlock sequencer.
// master = card controller or bench side, slave = the sequencer.
interface rpsc_interlock_seq_if #(
    parameter int N_FAULT = 7
);
    logic               LA_Test;
    logic               ack;
    logic               hv_req;
    logic [N_FAULT-1:0] fault_in;
    logic [N_FAULT-1:0] fault_mask;
    logic               hv_enable;
    logic               fan_on;
    logic               trip;
    logic [N_FAULT-1:0] lamp;
    logic [N_FAULT-1:0] first_fault;
    logic [1:0]         state_o;

    modport master (
        output LA_Test, ack, hv_req, fault_in, fault_mask,
        input  hv_enable, fan_on, trip, lamp, first_fault, state_o
    );

    modport slave (
        input  LA_Test, ack, hv_req, fault_in, fault_mask,
        output hv_enable, fan_on, trip, lamp, first_fault, state_o
    );
endinterface

// File: rtl/rpsc_debounce.sv
// Single-bit fault debouncer: output rises after DEBOUNCE_CYC consecutive
// high samples and drops on the first low sample.
module rpsc_debounce
    import rpsc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic db
);
    localparam int             CW  = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  MAX = CW'(DEBOUNCE_CYC);

    logic [CW-1:0] cnt;

    // Count consecutive high samples, saturating at MAX; any low sample restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (!din) begin
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            if (cnt != MAX) cnt <= cnt + 1'b1;
            // This edge is sample number cnt+1; accept once it reaches MAX.
            db <= (cnt >= MAX - 1'b1);
        end
    end
endmodule

// File: rtl/rpsc_interlock_seq.sv
// RPSC central fault-interlock sequencer: debounce, latch, first-out capture,
// HV/fan sequencing FSM and lamp drive.
// Optional feature: define RPSC_FIRST_OUT_EN to build the first-out register;
// otherwise first_fault is tied to 0.
module rpsc_interlock_seq
    import rpsc_pkg::*;
#(
    parameter int N_FAULT       = 7,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int FAN_DELAY_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    rpsc_interlock_seq_if.slave  bus
);
    localparam int            FW     = cnt_w(FAN_DELAY_CYC);
    localparam logic [FW-1:0] FAN_LD = FW'(FAN_DELAY_CYC);

    logic [N_FAULT-1:0] db;
    logic [N_FAULT-1:0] set_v;
    logic [N_FAULT-1:0] clr_v;
    logic [N_FAULT-1:0] latched;
    logic [N_FAULT-1:0] latched_nxt;
    logic               new_fault;
    logic               any_latched;
    logic [FW-1:0]      fan_cnt;
    seq_state_t         state, state_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < N_FAULT; gi++) begin : g_db
            rpsc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
                .clk   (clk),
                .reset (reset),
                .din   (bus.fault_in[gi]),
                .db    (db[gi])
            );
        end
    endgenerate

    // A set requires db=1, so its ack-clear term is already 0: set dominates ack.
    assign set_v       = db & ~bus.fault_mask;
    assign clr_v       = bus.ack ? ~db : '0;
    assign latched_nxt = (latched & ~clr_v) | set_v;
    assign new_fault   = |set_v;
    assign any_latched = |latched;

    // Fault latch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) latched <= '0;
        else       latched <= latched_nxt;
    end

`ifdef RPSC_FIRST_OUT_EN
    logic [N_FAULT-1:0] first_q;

    // Capture the lowest-index set when starting from a clean latch; drop when it empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                first_q <= '0;
        else if (~|latched_nxt)   first_q <= '0;
        else if (!any_latched)    first_q <= set_v & (~set_v + 1'b1);
    end

    assign bus.first_fault = first_q;
`else
    assign bus.first_fault = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.hv_req && !any_latched && !new_fault) state_nxt = RUN;
            RUN:  if (new_fault)                                 state_nxt = TRIP;
                  else if (!bus.hv_req)                          state_nxt = COOL;
            TRIP: if (!any_latched && !new_fault)                state_nxt = COOL;
            COOL: if (new_fault)                                 state_nxt = TRIP;
                  else if (fan_cnt == '0)                        state_nxt = IDLE;
            default:                                             state_nxt = IDLE;
        endcase
    end

    // Fan run-on: load on leaving RUN, count down to 0 in TRIP/COOL, never reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fan_cnt <= '0;
        else if (state == RUN && state_nxt != RUN)
            fan_cnt <= FAN_LD;
        else if ((state == TRIP || state == COOL) && fan_cnt != '0)
            fan_cnt <= fan_cnt - 1'b1;
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        bus.hv_enable = (state == RUN);
        bus.fan_on    = (state == RUN) || (fan_cnt != '0);
        bus.trip      = (state == TRIP);
        bus.state_o   = state;
        bus.lamp      = latched | {N_FAULT{bus.LA_Test}};
    end
endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Directed bench for rpsc_interlock_seq (N_FAULT=7, DEBOUNCE_CYC=4, FAN_DELAY_CYC=10).
module tb_rpsc_interlock_seq;
    localparam int N = 7;

`ifdef RPSC_FIRST_OUT_EN
    localparam logic FO = 1'b1;
`else
    localparam logic FO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    rpsc_interlock_seq_if #(.N_FAULT(N)) bus ();

    rpsc_interlock_seq #(
        .N_FAULT       (N),
        .DEBOUNCE_CYC  (4),
        .FAN_DELAY_CYC (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 30; k++) begin
            if (bus.state_o == 2'd0) break;
            step();
        end
        chk(tag, {30'd0, bus.state_o}, 32'd0);
    endtask

    initial begin
        int hi;
        reset          = 1'b1;
        bus.LA_Test    = 1'b0;
        bus.ack        = 1'b0;
        bus.hv_req     = 1'b0;
        bus.fault_in   = '0;
        bus.fault_mask = '0;
        #2;
        // 1. reset state and lamp test
        chk("rst_hv",    bus.hv_enable,   0);
        chk("rst_fan",   bus.fan_on,      0);
        chk("rst_trip",  bus.trip,        0);
        chk("rst_lamp",  bus.lamp,        0);
        chk("rst_first", bus.first_fault, 0);
        chk("rst_state", bus.state_o,     0);
        bus.LA_Test = 1'b1;
        #1;
        chk("lamptest_lamp", bus.lamp,      7'h7F);
        chk("lamptest_hv",   bus.hv_enable, 0);
        bus.LA_Test = 1'b0;
        step(2);
        reset = 1'b0;
        step();

        // 2. start / stop with fan run-on
        bus.hv_req = 1'b1;
        step();
        chk("start_hv",    bus.hv_enable, 1);
        chk("start_fan",   bus.fan_on,    1);
        chk("start_state", bus.state_o,   1);
        bus.hv_req = 1'b0;
        step();
        chk("stop_state", bus.state_o,   3);
        chk("stop_hv",    bus.hv_enable, 0);
        hi = 0;
        for (int k = 0; k < 20 && bus.fan_on; k++) begin
            hi++;
            step();
        end
        chk("runon_cycles", hi, 10);
        chk("runon_state",  bus.state_o, 3);
        step();
        chk("cool_idle", bus.state_o, 0);

        // 3. debounce: 3-cycle pulse rejected, 4-cycle pulse trips
        bus.hv_req = 1'b1;
        step();
        bus.fault_in = 7'h04;
        step(3);
        bus.fault_in = '0;
        step();
        chk("short_lamp",  bus.lamp,      0);
        chk("short_hv",    bus.hv_enable, 1);
        chk("short_state", bus.state_o,   1);
        bus.fault_in = 7'h04;
        step(4);
        chk("db4_still_run", bus.hv_enable, 1);
        bus.fault_in = '0;
        step();
        chk("db4_trip",  bus.trip,        1);
        chk("db4_hv",    bus.hv_enable,   0);
        chk("db4_lamp",  bus.lamp,        7'h04);
        chk("db4_fan",   bus.fan_on,      1);
        chk("db4_first", bus.first_fault, FO ? 7'h04 : 7'h00);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("db4_ack_lamp",  bus.lamp,    0);
        chk("db4_ack_state", bus.state_o, 2);
        step();
        chk("db4_cool", bus.state_o, 3);
        wait_idle("db4_to_idle");

        // 4. simultaneous faults, first-out, partial ack
        step();
        chk("sim_run", bus.state_o, 1);
        bus.fault_in = 7'h22;
        step(5);
        chk("sim_lamp",  bus.lamp,        7'h22);
        chk("sim_first", bus.first_fault, FO ? 7'h02 : 7'h00);
        chk("sim_trip",  bus.trip,        1);
        bus.fault_in = 7'h20;
        step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("pack_lamp",  bus.lamp,        7'h20);
        chk("pack_first", bus.first_fault, FO ? 7'h02 : 7'h00);
        chk("pack_state", bus.state_o,     2);
        bus.fault_in = '0;
        step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("fack_lamp",  bus.lamp,        0);
        chk("fack_first", bus.first_fault, 0);
        step();
        chk("fack_cool", bus.state_o, 3);
        bus.hv_req = 1'b0;
        wait_idle("sim_to_idle");

        // 5. masking
        bus.hv_req = 1'b1;
        step();
        bus.fault_mask = 7'h08;
        bus.fault_in   = 7'h08;
        step(6);
        chk("mask_lamp",  bus.lamp,      0);
        chk("mask_state", bus.state_o,   1);
        chk("mask_hv",    bus.hv_enable, 1);
        bus.fault_mask = '0;
        step();
        chk("unmask_trip", bus.trip, 1);
        chk("unmask_lamp", bus.lamp, 7'h08);

        // 6. fault during COOL keeps the running fan count; reset mid-TRIP
        bus.fault_in = '0;
        step();
        bus.ack    = 1'b1;
        bus.hv_req = 1'b0;
        step();
        bus.ack = 1'b0;
        step();
        chk("c6_cool", bus.state_o, 3);
        bus.fault_in = 7'h01;
        step(5);
        chk("c6_trip",     bus.state_o, 2);
        chk("c6_fan_left", bus.fan_on,  1);
        step(2);
        chk("c6_no_reload", bus.fan_on, 0);
        chk("c6_still_trip", bus.trip,  1);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", bus.state_o, 0);
        chk("mid_rst_fan",   bus.fan_on,  0);
        chk("mid_rst_trip",  bus.trip,    0);
        chk("mid_rst_lamp",  bus.lamp,    0);
        bus.fault_in = '0;
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
